app_mult_issuer: RTL and testbench
==================================

APP_MULT_ISSUER -- requirements
Module: app_mult_issuer

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits.
REQ-002 Parameter DEPTH, default 4: operand FIFO entries, power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  FIFO can accept a pair.
REQ-007 in_a, in_b  input  WIDTH each  operands.
REQ-008 mult_start  output  1  one-cycle start pulse to the approximate multiplier.
REQ-009 mult_a, mult_b  output  WIDTH each  operands presented to the multiplier.
REQ-010 mult_done  input  1  multiplier completion.
REQ-011 mult_result  input  2*WIDTH  multiplier product, valid while mult_done is high.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_result  output  2*WIDTH  product.

Function
REQ-015 The FIFO shall push when in_valid and in_ready are both high; in_ready shall equal "FIFO not full", with no same-cycle pop bypass when full.
REQ-016 FSM states shall be IDLE, ISSUE and WAIT.
REQ-017 IDLE->ISSUE: FIFO non-empty and the output slot free (out_valid low, or out_valid and out_ready high this cycle); pop the head into the mult_a/mult_b registers.
REQ-018 ISSUE: assert mult_start for exactly one cycle, then go to WAIT.
REQ-019 WAIT: on the first cycle mult_done is high, load out_result from mult_result, set out_valid, and go to IDLE; mult_a/mult_b shall stay stable from ISSUE through that cycle.
REQ-020 mult_done shall be ignored outside WAIT.
REQ-021 out_valid and out_result shall hold until out_valid and out_ready are both high; out_valid clears that cycle unless a new result loads in the same cycle.
REQ-022 Latency shall be in-accept to mult_start no less than 2 cycles when idle and empty, and mult_done to out_valid 1 cycle.
REQ-023 Results shall leave in operand-acceptance order, and at most one operation shall be in flight.
REQ-024 A FIFO push and pop in the same cycle shall leave the occupancy unchanged; pointers shall wrap modulo DEPTH.

Reset
REQ-025 Reset low shall clear, asynchronously: FSM to IDLE, FIFO empty (in_ready=1), mult_start=0, mult_a=mult_b=0, out_valid=0, out_result=0.
REQ-026 Reset mid-operation shall abandon the in-flight operation and FIFO contents, and a later stale mult_done shall be ignored.

Configuration
REQ-027 Macro APP_MULT_ZERO_BYPASS_EN shall control zero bypass. When defined, in IDLE, a head pair with either operand zero shall produce out_result=0 and out_valid next cycle, with the pop and no mult_start; the multiplier's leading-one search never terminates on zero. When undefined, all pairs go to the multiplier.

Structure
REQ-028 The shared package shall hold the FSM state enum and the default WIDTH/DEPTH constants.
REQ-029 The FIFO shall be a sub-module, issuer_fifo (parameters WIDTH, DEPTH; push, pop, full, empty).

Verification
REQ-030 After reset, push (3,5) with mult_done returned 4 cycles after mult_start, result 15 -> exactly one mult_start pulse, out_result=15, out_valid 1 cycle after mult_done.
REQ-031 Push DEPTH+1 pairs back-to-back with the multiplier stalled -> in_ready falls after DEPTH pushes; the extra pair is not accepted until a pop.
REQ-032 Hold out_ready low for 10 cycles with a result pending -> no new mult_start, and out_result stable.
REQ-033 With APP_MULT_ZERO_BYPASS_EN defined, push (0,9) then (2,2) -> first result 0 with no mult_start; second result 4 after one mult_start.
REQ-034 Assert rst low during WAIT, then pulse mult_done after release -> out_valid stays 0 and the FIFO is empty.

Source files
------------

// File: rtl/app_mult_issuer_pkg.sv
// Shared types and defaults for the approximate-multiplier issuer.
// Holds the sequencer state encoding and the default operand/FIFO sizing.
package app_mult_issuer_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } issuer_state_t;

endpackage

// File: rtl/app_mult_issuer_if.sv
// Handshake bundle between the issuer, its operand source, the multiplier and the result sink.
// slave is the issuer side, master is the environment side.
interface app_mult_issuer_if
    import app_mult_issuer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 mult_start;
    logic [WIDTH-1:0]     mult_a;
    logic [WIDTH-1:0]     mult_b;
    logic                 mult_done;
    logic [2*WIDTH-1:0]   mult_result;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_result;

    modport slave (
        input  in_valid, in_a, in_b, mult_done, mult_result, out_ready,
        output in_ready, mult_start, mult_a, mult_b, out_valid, out_result
    );

    modport master (
        output in_valid, in_a, in_b, mult_done, mult_result, out_ready,
        input  in_ready, mult_start, mult_a, mult_b, out_valid, out_result
    );

endinterface

// File: rtl/app_mult_issuer_fifo.sv
// Operand-pair FIFO for the issuer (module issuer_fifo). DEPTH must be a power of two,
// so the pointers wrap by natural overflow; a full FIFO refuses pushes even when popping.
module issuer_fifo
    import app_mult_issuer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_a,
    input  logic [WIDTH-1:0] wr_b,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_a,
    output logic [WIDTH-1:0] rd_b
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_a    = mem_a[rd_ptr];
    assign rd_b    = mem_b[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_a[wr_ptr] <= wr_a;
            mem_b[wr_ptr] <= wr_b;
        end
    end

endmodule

// File: rtl/app_mult_issuer.sv
// Issues buffered operand pairs one at a time to an approximate multiplier and holds each product
// until accepted. Define APP_MULT_ZERO_BYPASS_EN to answer zero-operand pairs without the multiplier.
module app_mult_issuer
    import app_mult_issuer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    app_mult_issuer_if.slave  bus
);

    // state    | meaning
    // ST_IDLE  | waiting for a queued pair and a free output slot
    // ST_ISSUE | mult_start asserted for this single cycle
    // ST_WAIT  | operands held, waiting for mult_done

    issuer_state_t        state;
    issuer_state_t        state_nxt;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [WIDTH-1:0]     head_a;
    logic [WIDTH-1:0]     head_b;
    logic                 load_ops;
    logic                 load_res;
    logic [2*WIDTH-1:0]   res_nxt;
    logic                 slot_free;
    logic [WIDTH-1:0]     mult_a_q;
    logic [WIDTH-1:0]     mult_b_q;
    logic                 out_valid_q;
    logic [2*WIDTH-1:0]   out_result_q;

    issuer_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .pop   (fifo_pop),
        .wr_a  (bus.in_a),
        .wr_b  (bus.in_b),
        .full  (fifo_full),
        .empty (fifo_empty),
        .rd_a  (head_a),
        .rd_b  (head_b)
    );

    // The slot frees in the same cycle the sink takes the pending result.
    assign slot_free = !out_valid_q || bus.out_ready;

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        load_ops  = 1'b0;
        load_res  = 1'b0;
        res_nxt   = bus.mult_result;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && slot_free) begin
                    fifo_pop = 1'b1;
`ifdef APP_MULT_ZERO_BYPASS_EN
                    if (head_a == '0 || head_b == '0) begin
                        load_res = 1'b1;
                        res_nxt  = '0;
                    end else begin
                        load_ops  = 1'b1;
                        state_nxt = ST_ISSUE;
                    end
`else
                    load_ops  = 1'b1;
                    state_nxt = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (bus.mult_done) begin
                    load_res  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mult_a_q <= '0;
            mult_b_q <= '0;
        end else if (load_ops) begin
            mult_a_q <= head_a;
            mult_b_q <= head_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else if (load_res) begin
            out_valid_q  <= 1'b1;
            out_result_q <= res_nxt;
        end else if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.mult_start = (state == ST_ISSUE);
    assign bus.mult_a     = mult_a_q;
    assign bus.mult_b     = mult_b_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;

endmodule

// File: tb/tb_app_mult_issuer.sv
// Self-checking bench for app_mult_issuer: behavioural multiplier with programmable latency,
// negedge monitor, and an in-order scoreboard of expected products.
module tb_app_mult_issuer;

    localparam int W = 16;
    localparam int D = 4;
`ifdef APP_MULT_ZERO_BYPASS_EN
    localparam int ZERO_STARTS = 1;
`else
    localparam int ZERO_STARTS = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    app_mult_issuer_if #(.WIDTH(W)) bus ();

    app_mult_issuer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [2*W-1:0] exp_q [$];
    logic [2*W-1:0] e;
    int             rd_idx = 0;
    int             acc_cyc = 0;

    // multiplier model
    int         mult_delay = 4;
    logic       force_done = 1'b0;
    int         mcnt = 0;
    logic [W-1:0] cap_a = '0;
    logic [W-1:0] cap_b = '0;

    initial begin
        bus.mult_done   = 1'b0;
        bus.mult_result = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mult_done = 1'b0;
            if (!rst) begin
                mcnt = 0;
            end else if (force_done) begin
                bus.mult_done   = 1'b1;
                bus.mult_result = (2*W)'(cap_a) * (2*W)'(cap_b);
                mcnt = 0;
            end else if (bus.mult_start) begin
                cap_a = bus.mult_a;
                cap_b = bus.mult_b;
                mcnt  = mult_delay;
            end else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    bus.mult_done   = 1'b1;
                    bus.mult_result = (2*W)'(cap_a) * (2*W)'(cap_b);
                end
            end
        end
    end

    // monitor
    int           cyc = 0;
    int           start_cnt = 0;
    int           last_start_cyc = 0;
    int           last_done_cyc = 0;
    int           ov_rise_cyc = 0;
    int           ab_unstable = 0;
    int           got_n = 0;
    logic         ov_prev = 1'b0;
    logic         busy = 1'b0;
    logic [W-1:0] sa = '0;
    logic [W-1:0] sb = '0;
    logic [2*W-1:0] got_res [64];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            busy    = 1'b0;
            ov_prev = 1'b0;
        end else begin
            if (bus.mult_start) begin
                start_cnt++;
                last_start_cyc = cyc;
                busy = 1'b1;
                sa   = bus.mult_a;
                sb   = bus.mult_b;
            end else if (busy && (bus.mult_a !== sa || bus.mult_b !== sb)) begin
                ab_unstable++;
            end
            if (bus.mult_done) begin
                last_done_cyc = cyc;
                busy = 1'b0;
            end
            if (bus.out_valid && !ov_prev) ov_rise_cyc = cyc;
            ov_prev = bus.out_valid;
            if (bus.out_valid && bus.out_ready && got_n < 64) begin
                got_res[got_n] = bus.out_result;
                got_n++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        while (!bus.in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout a=%0d b=%0d in_ready stayed 0", a, b);
        end else begin
            acc_cyc = cyc;
            exp_q.push_back((2*W)'(a) * (2*W)'(b));
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int w = 0;
        while (got_n < rd_idx + n && w < 300) begin
            tick();
            w++;
        end
        if (got_n < rd_idx + n) begin
            checks++;
            failures++;
            $display("FAIL result_timeout got=%0d required=%0d", got_n - rd_idx, n);
        end
    endtask

    task automatic force_pulse();
        @(negedge clk);
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        #2 rst = 1'b0;
        tick();
        tick();
        checks++; if (bus.in_ready !== 1'b1)  begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.mult_start !== 1'b0) begin failures++; $display("FAIL rst_mult_start got=%b exp=0", bus.mult_start); end
        checks++; if (bus.mult_a !== '0)      begin failures++; $display("FAIL rst_mult_a got=%0d exp=0", bus.mult_a); end
        checks++; if (bus.mult_b !== '0)      begin failures++; $display("FAIL rst_mult_b got=%0d exp=0", bus.mult_b); end
        checks++; if (bus.out_result !== '0)  begin failures++; $display("FAIL rst_out_result got=%0d exp=0", bus.out_result); end
        rst = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_basic();
        int s0 = start_cnt;
        mult_delay = 4;
        push_pair(16'd3, 16'd5);
        wait_results(1);
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_idx >= got_n) begin failures++; $display("FAIL basic_missing exp=%0d", e); end
            else begin
                if (got_res[rd_idx] !== e) begin failures++; $display("FAIL basic_result got=%0d exp=%0d", got_res[rd_idx], e); end
                rd_idx++;
            end
        end
        checks++; if (start_cnt - s0 != 1) begin failures++; $display("FAIL basic_starts got=%0d exp=1", start_cnt - s0); end
        checks++; if (ov_rise_cyc - last_done_cyc != 1) begin failures++; $display("FAIL basic_done_to_valid got=%0d exp=1", ov_rise_cyc - last_done_cyc); end
        checks++; if (last_start_cyc - acc_cyc < 2 || last_start_cyc - acc_cyc > 3) begin
            failures++; $display("FAIL basic_accept_to_start got=%0d exp=2..3", last_start_cyc - acc_cyc);
        end
    endtask

    task automatic test_fill();
        int acc = 0;
        int stalls;
        logic ir;
        logic extra_ok = 1'b0;
        mult_delay = 0;
        bus.out_ready = 1'b1;
        push_pair(16'd1, 16'd1);
        repeat (3) tick();
        for (int i = 0; i <= D; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = W'(i + 2);
            bus.in_b     = 16'd3;
            @(negedge clk);
            stalls = 0;
            while (!bus.in_ready && stalls < 6) begin
                stalls++;
                @(negedge clk);
            end
            if (!bus.in_ready) break;
            exp_q.push_back((2*W)'(i + 2) * 3);
            acc++;
            tick();
        end
        ir = bus.in_ready;
        checks++; if (acc != D) begin failures++; $display("FAIL fill_accepted got=%0d exp=%0d", acc, D); end
        checks++; if (ir !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", ir); end
        mult_delay = 2;
        force_pulse();
        stalls = 0;
        while (!bus.in_ready && stalls < 10) begin
            stalls++;
            @(negedge clk);
        end
        if (bus.in_ready) begin
            extra_ok = 1'b1;
            exp_q.push_back((2*W)'(D + 2) * 3);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++; if (extra_ok !== 1'b1) begin failures++; $display("FAIL fill_extra_after_pop got=%b exp=1", extra_ok); end
        wait_results(exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_idx >= got_n) begin failures++; $display("FAIL fill_missing exp=%0d", e); end
            else begin
                if (got_res[rd_idx] !== e) begin failures++; $display("FAIL fill_order got=%0d exp=%0d", got_res[rd_idx], e); end
                rd_idx++;
            end
        end
    endtask

    task automatic test_backpressure();
        int s0;
        int w = 0;
        int changed = 0;
        logic [2*W-1:0] r0;
        mult_delay = 3;
        bus.out_ready = 1'b0;
        push_pair(16'd7, 16'd8);
        push_pair(16'd9, 16'd10);
        while (!bus.out_valid && w < 50) begin tick(); w++; end
        s0 = start_cnt;
        r0 = bus.out_result;
        repeat (10) begin
            tick();
            if (bus.out_result !== r0 || bus.out_valid !== 1'b1) changed++;
        end
        checks++; if (start_cnt != s0) begin failures++; $display("FAIL bp_no_start got=%0d exp=%0d", start_cnt, s0); end
        checks++; if (changed != 0) begin failures++; $display("FAIL bp_hold changes=%0d exp=0", changed); end
        checks++; if (r0 !== 32'd56) begin failures++; $display("FAIL bp_pending got=%0d exp=56", r0); end
        bus.out_ready = 1'b1;
        wait_results(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_idx >= got_n) begin failures++; $display("FAIL bp_missing exp=%0d", e); end
            else begin
                if (got_res[rd_idx] !== e) begin failures++; $display("FAIL bp_result got=%0d exp=%0d", got_res[rd_idx], e); end
                rd_idx++;
            end
        end
    endtask

    task automatic test_zero();
        int s0 = start_cnt;
        mult_delay = 3;
        bus.out_ready = 1'b1;
        push_pair(16'd0, 16'd9);
        push_pair(16'd2, 16'd2);
        wait_results(2);
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_idx >= got_n) begin failures++; $display("FAIL zero_missing exp=%0d", e); end
            else begin
                if (got_res[rd_idx] !== e) begin failures++; $display("FAIL zero_result got=%0d exp=%0d", got_res[rd_idx], e); end
                rd_idx++;
            end
        end
        checks++; if (start_cnt - s0 != ZERO_STARTS) begin
            failures++; $display("FAIL zero_starts got=%0d exp=%0d", start_cnt - s0, ZERO_STARTS);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        mult_delay = 0;
        bus.out_ready = 1'b1;
        push_pair(16'd4, 16'd4);
        push_pair(16'd5, 16'd5);
        repeat (4) tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        exp_q.delete();
        rd_idx = got_n;
        s0 = start_cnt;
        tick();
        force_pulse();
        repeat (5) tick();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1)  begin failures++; $display("FAIL rmid_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (start_cnt != s0)        begin failures++; $display("FAIL rmid_fifo_empty starts=%0d exp=%0d", start_cnt, s0); end
        checks++; if (got_n != rd_idx)        begin failures++; $display("FAIL rmid_no_result got=%0d exp=%0d", got_n, rd_idx); end
        mult_delay = 2;
        push_pair(16'd6, 16'd7);
        wait_results(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_idx >= got_n) begin failures++; $display("FAIL rmid_missing exp=%0d", e); end
            else begin
                if (got_res[rd_idx] !== e) begin failures++; $display("FAIL rmid_result got=%0d exp=%0d", got_res[rd_idx], e); end
                rd_idx++;
            end
        end
    endtask

    task automatic test_operand_hold();
        checks++;
        if (ab_unstable != 0) begin failures++; $display("FAIL operand_hold changes=%0d exp=0", ab_unstable); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_backpressure();
        test_zero();
        test_reset_mid();
        test_operand_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
